mul_const_23_serial: RTL and testbench

MUL_CONST_23_SERIAL -- requirements
Module: mul_const_23_serial

---
 rtl/mul_const_23_serial.sv | 122 ++++++++++++
 tb/tb_mul_const_23_serial.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mul_const_23_serial.sv
`default_nettype none
// ============================================================================
// Module   : mul_const_23_serial
// Purpose  : Rebuilds a dividend from a divide-by-23 quotient/remainder pair:
//            out_y = in_q*23 + in_r. The product is formed serially, one
//            quotient nibble per cycle, with the remainder as the initial
//            carry-in. Handshaked on both sides; one operation in flight.
// Options  : define MUL23_RANGE_CHECK_EN to add the out_err port, which flags
//            a remainder outside 0..22.
// Revision : 1.0 - initial release
// ============================================================================
module mul_const_23_serial #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_q,
   input  logic [4:0]   in_r,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W+4:0] out_y
`ifdef MUL23_RANGE_CHECK_EN
   ,
   output logic         out_err
`endif
);

   localparam int NIB = W / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state;
   logic [1:0]    next_state;
   logic [W-1:0]  shreg;   // remaining quotient nibbles, current one at [3:0]
   logic [4:0]    carry;   // bounded to 0..31 on load, 0..23 afterwards
   logic [CW-1:0] cnt;
   logic [8:0]    nib9;
   logic [8:0]    p;
   logic          last;

   assign last = (cnt == LAST_NIB);

   // One digit step: 15*23 + 31 = 376 fits in 9 bits, so p[8:4] never exceeds 23.
   always_comb begin
      nib9 = {5'd0, shreg[3:0]};
      p    = (nib9 * 9'd23) + {4'd0, carry};
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   // Next-state logic: accept in IDLE, step W/4 nibbles in RUN, hold in DONE.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (in_valid)  next_state = S_RUN;
         S_RUN:   if (last)      next_state = S_DONE;
         S_DONE:  if (out_ready) next_state = S_IDLE;
         default:                next_state = S_IDLE;
      endcase
   end

   // Handshake outputs decode directly from state so reset acts on them at once.
   always_comb begin
      in_ready  = (state == S_IDLE);
      out_valid = (state == S_DONE);
   end

   // Datapath: load operands on accept, then produce one result nibble per cycle.
   // Result nibbles enter at the top of out_y[W-1:0] and shift down, so after
   // W/4 steps nibble k sits at bits [4k+3:4k]; the top field tracks the carry
   // and holds the final carry once the last nibble is done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg <= '0;
         carry <= '0;
         cnt   <= '0;
         out_y <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  shreg <= in_q;
                  carry <= in_r;
                  cnt   <= '0;
               end
            end
            S_RUN: begin
               shreg          <= shreg >> 4;
               carry          <= p[8:4];
               cnt            <= cnt + 1'b1;
               out_y[W-1:0]   <= {p[3:0], out_y[W-1:4]};
               out_y[W+4:W]   <= p[8:4];
            end
            default: ;
         endcase
      end
   end

`ifdef MUL23_RANGE_CHECK_EN
   // Remainder range flag: captured on accept, held through DONE, cleared on consume.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         out_err <= 1'b0;
      else if ((state == S_IDLE) && in_valid)
         out_err <= (in_r >= 5'd23);
      else if ((state == S_DONE) && out_ready)
         out_err <= 1'b0;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_const_23_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_const_23_serial
// Purpose  : Directed self-checking bench for mul_const_23_serial at W=64.
//            Honours MUL23_RANGE_CHECK_EN to also check out_err.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_const_23_serial;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_q;
   logic [4:0]    in_r;
   logic          out_valid;
   logic          out_ready;
   logic [W+4:0]  out_y;
`ifdef MUL23_RANGE_CHECK_EN
   logic          out_err;
`endif

   int checks   = 0;
   int failures = 0;

   mul_const_23_serial #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_q      (in_q),
      .in_r      (in_r),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y)
`ifdef MUL23_RANGE_CHECK_EN
      ,
      .out_err   (out_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] q;
      logic [4:0]  r;
      logic [68:0] y;
      logic        err;
   } vec_t;

   task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   // Wait for out_valid, counting rising edges since the input handshake.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // Full operation: handshake, latency/result/flag checks, consume.
   task automatic do_op(input int idx, input logic [63:0] q, input logic [4:0] r,
                        input logic [68:0] ey, input logic ee);
      int lat;
      @(negedge clk);
      check($sformatf("v%0d_in_ready", idx), 69'(in_ready), 69'd1);
      in_valid = 1'b1; in_q = q; in_r = r;
      @(posedge clk); #1;
      // Garbage on the inputs while busy must be ignored.
      in_valid = 1'b0; in_q = ~q; in_r = 5'd31;
      wait_done(lat);
      check($sformatf("v%0d_latency", idx), 69'(lat), 69'd16);
      check($sformatf("v%0d_y", idx), out_y, ey);
`ifdef MUL23_RANGE_CHECK_EN
      check($sformatf("v%0d_err", idx), 69'(out_err), 69'(ee));
`else
      if (ee) begin end
`endif
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      check($sformatf("v%0d_ready_after", idx), 69'({in_ready, out_valid}), 69'b10);
`ifdef MUL23_RANGE_CHECK_EN
      check($sformatf("v%0d_err_clr", idx), 69'(out_err), 69'd0);
`endif
   endtask

   initial begin
      vec_t vecs[6];
      int   lat;
      logic seen;

      vecs[0] = '{64'd0,                   5'd0,  69'h0,                    1'b0};
      vecs[1] = '{64'd1,                   5'd0,  69'h17,                   1'b0};
      vecs[2] = '{64'd100,                 5'd5,  69'h901,                  1'b0};
      vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 5'd22, 69'h16_FFFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[4] = '{64'd2,                   5'd23, 69'h45,                   1'b1};
      vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 69'h17_0000_0000_0000_0008, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; in_q = '0; in_r = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready",  69'(in_ready),  69'd1);
      check("reset_out_valid", 69'(out_valid), 69'd0);
      check("reset_out_y",     out_y,          69'd0);
`ifdef MUL23_RANGE_CHECK_EN
      check("reset_out_err",   69'(out_err),   69'd0);
`endif
      @(negedge clk); rst_n = 1'b1;

      // Table-driven vectors.
      for (int i = 0; i < 6; i++)
         do_op(i, vecs[i].q, vecs[i].r, vecs[i].y, vecs[i].err);

      // Reset 8 cycles into RUN: everything clears at once, no result appears.
      @(negedge clk);
      in_valid = 1'b1; in_q = 64'h0123_4567_89AB_CDEF; in_r = 5'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1; rst_n = 1'b0; #1;
      check("midrst_in_ready",  69'(in_ready),  69'd1);
      check("midrst_out_valid", 69'(out_valid), 69'd0);
      check("midrst_out_y",     out_y,          69'd0);
      // Release and offer a new operand at the first edge after release.
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b1; in_q = 64'd5; in_r = 5'd1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("postrst_accepted", 69'(in_ready), 69'd0);
      seen = 1'b0;
      lat  = 0;
      while (!out_valid && lat < 64) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid && lat < 16) seen = 1'b1;
      end
      check("postrst_no_early_valid", 69'(seen), 69'd0);
      check("postrst_latency", 69'(lat), 69'd16);
      check("postrst_y", out_y, 69'h74);
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;

      // Backpressure: five cycles of out_ready=0 with a competing in_valid.
      @(negedge clk);
      in_valid = 1'b1; in_q = 64'd100; in_r = 5'd5;
      @(posedge clk); #1;
      in_q = 64'hDEAD_BEEF_0000_0001; in_r = 5'd7;
      wait_done(lat);
      check("bp_latency", 69'(lat), 69'd16);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check($sformatf("bp%0d_valid", i), 69'(out_valid), 69'd1);
         check($sformatf("bp%0d_y", i),     out_y,          69'h901);
         check($sformatf("bp%0d_ready", i), 69'(in_ready),  69'd0);
      end
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      check("bp_in_ready_after", 69'(in_ready),  69'd1);
      check("bp_valid_after",    69'(out_valid), 69'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
